// File: rtl/conv_mac_seq.sv
// Sequencer driving one two-stage mac unit through a valid-mode 1-D convolution.
// Optional stall counter port enabled by defining CONV_MAC_SEQ_STALL_CNT_EN.
module conv_mac_seq #(
  parameter int N = 16,
  parameter int M = 4,
  localparam int YN = N - M + 1,
  localparam int XW = (N > 1) ? $clog2(N) : 1,
  localparam int FW = (M > 1) ? $clog2(M) : 1,
  localparam int YW = (YN > 1) ? $clog2(YN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_addr,
  output logic [FW-1:0] f_addr,
  output logic          en_mult_reg,
  output logic          en_adder_reg,
  output logic          reset_accum,
  output logic          y_valid,
  input  logic          y_ready,
`ifdef CONV_MAC_SEQ_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic [YW-1:0] y_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   tap_q, tap_d;
  logic [YW-1:0]   y_idx_q, y_idx_d;
  logic            drain_q, drain_d;
  logic            run_vld_p1_q, run_vld_p2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      y_idx_q      <= '0;
      drain_q      <= 1'b0;
      run_vld_p1_q <= 1'b0;
      run_vld_p2_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      y_idx_q      <= y_idx_d;
      drain_q      <= drain_d;
      // stage boundary: RUN address cycle -> read data / multiply -> accumulate
      run_vld_p1_q <= (state_q == S_RUN);
      run_vld_p2_q <= run_vld_p1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    y_idx_d      = y_idx_q;
    drain_d      = drain_q;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    x_addr       = '0;
    f_addr       = '0;
    reset_accum  = 1'b0;
    y_valid      = 1'b0;
    y_addr       = y_idx_q;
    en_mult_reg  = run_vld_p1_q;
    en_adder_reg = run_vld_p2_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        reset_accum = 1'b1;
        tap_d       = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        // y_idx + tap never exceeds N-1, so no wrap handling is needed
        x_addr = XW'(y_idx_q) + XW'(tap_q);
        f_addr = tap_q;
        if (tap_q == FW'(M - 1)) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          tap_d = tap_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_OUT;
        else         drain_d = 1'b1;
      end
      S_OUT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          if (y_idx_q == YW'(N - M)) begin
            state_d = S_DONE;
          end else begin
            y_idx_d = y_idx_q + YW'(1);
            state_d = S_CLR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        y_idx_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CONV_MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (y_valid && !y_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/conv_mac_seq.md
# conv_mac_seq

Sequencer for one `mac` unit computing a valid-mode 1-D convolution y[i] = ReLU(sum over k of x[i+k]·f[k]) over an N-sample input and an M-tap filter. It issues x/f memory read addresses and drives the MAC's `en_mult_reg`, `en_adder_reg` and `reset_accum` in step with the MAC's two-stage pipeline. It presents each finished output on a valid/ready port. It sits between the layer-level start/done control and the `mac` + x/f memory datapath.

## Interface
- N, 16, input vector length (samples)
- M, 4, filter length (taps); N ≥ M ≥ 1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a convolution; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse after the last output is accepted
- x_addr  out  $clog2(N)  x memory read address (synchronous-read memory, 1-cycle latency)
- f_addr  out  $clog2(M)  f memory read address
- en_mult_reg  out  1  to mac: multiplier register enable
- en_adder_reg  out  1  to mac: accumulator register enable
- reset_accum  out  1  to mac: clears both MAC registers
- y_valid  out  1  mac accum_in holds finished y[y_addr]
- y_ready  in  1  consumer accepts output when y_valid && y_ready
- y_addr  out  $clog2(N-M+1)  index of current output, 0..N-M

## Operation
- States: IDLE, CLR, RUN, DRAIN, OUT, DONE.
- IDLE: start=1 → CLR. start while not IDLE is ignored.
- CLR (1 cycle): reset_accum=1 → RUN, tap=0.
- RUN (M cycles): x_addr=y_idx+tap, f_addr=tap; tap increments each cycle; after tap=M-1 → DRAIN.
- DRAIN (2 cycles): no address issued → OUT.
- OUT: y_valid=1, y_addr=y_idx; hold until y_ready. On accept: if y_idx=N-M → DONE, else y_idx+1 → CLR.
- DONE (1 cycle): done=1 → IDLE; y_idx cleared.
- Pipeline enables: en_mult_reg=1 exactly one cycle after each RUN cycle, when f/x read data arrives. en_adder_reg=1 exactly two cycles after each RUN cycle. Implement as a 2-deep shift register of the RUN-active bit. Exactly M pulses of each per output.
- Address arithmetic: y_idx+tap ≤ N-1 always, with no wrap. Counters sized by $clog2 with a minimum of 1 bit.
- Saturation and ReLU stay in mac; this block does no arithmetic on data.
- Outside RUN, x_addr and f_addr are 0. Outside OUT, y_valid is 0 and y_addr holds y_idx.

## Timing
- Reset (any state, mid-output included) → next cycle IDLE. All outputs 0: busy, done, y_valid, enables, reset_accum, x_addr, f_addr, y_addr. The pipeline shift register is cleared, so no stray enables follow.
- Start accepted at edge of cycle 0. CLR in cycle 1, RUN in cycles 2..M+1, DRAIN in M+2..M+3, y_valid first high in cycle M+4.
- Output period with y_ready held high is M+4 cycles, and 8 for M=4.
- y_ready low in OUT stretches OUT. The MAC holds its value because no enable is asserted.
- y_valid and start in the same cycle: start is ignored.
- done is high the cycle after the final accept. busy drops the cycle after done. A start in the done cycle is ignored; start is accepted again from the next cycle.

## Configuration
- CONV_MAC_SEQ_STALL_CNT_EN defined: adds output port stall_cnt (out, 16). It counts cycles with y_valid && !y_ready, saturates at 16'hFFFF, clears on accepted start and on reset, and holds its value after done.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- N=16, M=4, y_ready tied 1, start in cycle 0: y_valid in cycles 8,16,…,104 with y_addr 0..12. done pulse in cycle 105. busy high in cycles 1..105.
- Same run, checking addresses: in output i, RUN cycles give x_addr i,i+1,i+2,i+3 and f_addr 0,1,2,3. en_mult_reg is high for 4 cycles, lagging RUN by 1. en_adder_reg is high for 4 cycles, lagging RUN by 2.
- y_ready low for 5 cycles during output 3: y_valid held 6 cycles with y_addr=3 and no enables pulsed. Subsequent outputs shift by 5. With the macro defined, stall_cnt=5 at the end.
- reset asserted in the second RUN cycle of output 2: next cycle all outputs 0 and state IDLE, with no en_* pulses after reset. A new start then yields y_addr 0 first.
- start pulsed repeatedly while busy: output sequence and done timing are identical to the single-start case.
- N=M=4: exactly one output, y_valid in cycle 8, done in cycle 9.
